// File: rtl/outlier_writeback.sv
// Drains the outlier FIFO and zeroes each outlier's 16-bit lane in the x/y/z point BRAMs by read-modify-write.
// Optional WB_SCAN_EN: after the drain, stream every point whose x lane is non-zero on pt_* before finishing.
module outlier_writeback #(
  parameter int N         = 16,
  parameter int BUS_SIZE  = 32,
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 8548
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                empty,
  output logic                read_fifo,
  input  logic [N-1:0]        outlier_pos_fifo,
  output logic                bram_en,
  output logic                bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  input  logic [BUS_SIZE-1:0] bram_rdata_x,
  input  logic [BUS_SIZE-1:0] bram_rdata_y,
  input  logic [BUS_SIZE-1:0] bram_rdata_z,
  output logic [BUS_SIZE-1:0] bram_wdata_x,
  output logic [BUS_SIZE-1:0] bram_wdata_y,
  output logic [BUS_SIZE-1:0] bram_wdata_z,
  output logic                busy,
  output logic                wb_done,
  output logic [N-1:0]        outlier_count
`ifdef WB_SCAN_EN
  ,
  output logic                pt_valid,
  input  logic                pt_ready,
  output logic [N-1:0]        pt_x,
  output logic [N-1:0]        pt_y,
  output logic [N-1:0]        pt_z
`endif
);

  // state  | meaning
  // IDLE   | waiting for start
  // POP    | read_fifo pulse
  // FDATA  | popped position valid; range check, issue read
  // RD     | BRAM read enabled
  // RWAIT  | read data returning; build masked write data
  // WR     | BRAM write of all three lanes
  // CHECK  | more outliers -> POP, else finish (or scan)
  // DONE   | wb_done held until start drops
  // SRD    | scan: read of scan_word enabled
  // SLAT   | scan: latch word, present first non-zero lane
  // EMIT   | scan: hold point until pt_ready
  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_FDATA, S_RD, S_RWAIT, S_WR, S_CHECK, S_DONE, S_SRD, S_SLAT, S_EMIT
  } state_t;

  localparam logic [N-1:0]        MAX_POS_WORD = N'(MAX_WORDS);
  localparam logic [BUS_SIZE-1:0] LANE0_MASK   = BUS_SIZE'({N{1'b1}});

  state_t              state;
  logic [BUS_SIZE-1:0] lane_mask;

`ifdef WB_SCAN_EN
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MAX_WORDS - 1);
  logic [ADDR_W-1:0]   scan_word;
  logic [BUS_SIZE-1:0] buf_x, buf_y, buf_z;
  logic                lane_sel;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      read_fifo     <= 1'b0;
      bram_en       <= 1'b0;
      bram_we       <= 1'b0;
      bram_addr     <= '0;
      bram_wdata_x  <= '0;
      bram_wdata_y  <= '0;
      bram_wdata_z  <= '0;
      busy          <= 1'b0;
      wb_done       <= 1'b0;
      outlier_count <= '0;
      lane_mask     <= '0;
`ifdef WB_SCAN_EN
      pt_valid  <= 1'b0;
      pt_x      <= '0;
      pt_y      <= '0;
      pt_z      <= '0;
      scan_word <= '0;
      buf_x     <= '0;
      buf_y     <= '0;
      buf_z     <= '0;
      lane_sel  <= 1'b0;
`endif
    end else begin
      // Strobes are one-cycle; write data is only non-zero alongside bram_we.
      read_fifo    <= 1'b0;
      bram_en      <= 1'b0;
      bram_we      <= 1'b0;
      bram_wdata_x <= '0;
      bram_wdata_y <= '0;
      bram_wdata_z <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (empty) begin
              state   <= S_DONE;
              wb_done <= 1'b1;
            end else begin
              state     <= S_POP;
              read_fifo <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        S_POP: state <= S_FDATA;
        S_FDATA: begin
          if (outlier_pos_fifo == '0 || {1'b0, outlier_pos_fifo[N-1:1]} >= MAX_POS_WORD) begin
            state <= S_CHECK;
          end else begin
            state     <= S_RD;
            bram_en   <= 1'b1;
            bram_addr <= ADDR_W'(outlier_pos_fifo >> 1);
            lane_mask <= outlier_pos_fifo[0] ? (LANE0_MASK << N) : LANE0_MASK;
          end
        end
        S_RD: state <= S_RWAIT;
        S_RWAIT: begin
          state        <= S_WR;
          bram_en      <= 1'b1;
          bram_we      <= 1'b1;
          bram_wdata_x <= bram_rdata_x & ~lane_mask;
          bram_wdata_y <= bram_rdata_y & ~lane_mask;
          bram_wdata_z <= bram_rdata_z & ~lane_mask;
        end
        S_WR: begin
          state <= S_CHECK;
          if (outlier_count != '1) outlier_count <= outlier_count + 1'b1;
        end
        S_CHECK: begin
          if (!empty) begin
            state     <= S_POP;
            read_fifo <= 1'b1;
          end else begin
`ifdef WB_SCAN_EN
            state     <= S_SRD;
            bram_en   <= 1'b1;
            bram_addr <= '0;
            scan_word <= '0;
`else
            state   <= S_DONE;
            busy    <= 1'b0;
            wb_done <= 1'b1;
`endif
          end
        end
`ifdef WB_SCAN_EN
        S_SRD: state <= S_SLAT;
        S_SLAT: begin
          buf_x <= bram_rdata_x;
          buf_y <= bram_rdata_y;
          buf_z <= bram_rdata_z;
          state <= S_EMIT;
          if (bram_rdata_x[N-1:0] != '0) begin
            pt_valid <= 1'b1;
            lane_sel <= 1'b0;
            pt_x     <= bram_rdata_x[N-1:0];
            pt_y     <= bram_rdata_y[N-1:0];
            pt_z     <= bram_rdata_z[N-1:0];
          end else if (bram_rdata_x[2*N-1:N] != '0) begin
            pt_valid <= 1'b1;
            lane_sel <= 1'b1;
            pt_x     <= bram_rdata_x[2*N-1:N];
            pt_y     <= bram_rdata_y[2*N-1:N];
            pt_z     <= bram_rdata_z[2*N-1:N];
          end else begin
            pt_valid <= 1'b0;
            lane_sel <= 1'b1;
          end
        end
        S_EMIT: begin
          if (!pt_valid || pt_ready) begin
            pt_valid <= 1'b0;
            if (!lane_sel && buf_x[2*N-1:N] != '0) begin
              pt_valid <= 1'b1;
              lane_sel <= 1'b1;
              pt_x     <= buf_x[2*N-1:N];
              pt_y     <= buf_y[2*N-1:N];
              pt_z     <= buf_z[2*N-1:N];
            end else if (scan_word == LAST_WORD) begin
              state   <= S_DONE;
              busy    <= 1'b0;
              wb_done <= 1'b1;
            end else begin
              state     <= S_SRD;
              bram_en   <= 1'b1;
              bram_addr <= scan_word + 1'b1;
              scan_word <= scan_word + 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          if (!start) begin
            state   <= S_IDLE;
            wb_done <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outlier_writeback.sv
// Bench for outlier_writeback: FIFO and BRAM behavioural models, per-scenario tasks against a word/lane reference.
module tb_outlier_writeback;

`ifdef WB_SCAN_EN
  localparam int MW = 16;
`else
  localparam int MW = 8548;
`endif
  localparam int N = 16;
  localparam int BW = 32;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          empty;
  logic          read_fifo;
  logic [N-1:0]  outlier_pos_fifo = '0;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [BW-1:0] bram_rdata_x = '0, bram_rdata_y = '0, bram_rdata_z = '0;
  logic [BW-1:0] bram_wdata_x, bram_wdata_y, bram_wdata_z;
  logic          busy, wb_done;
  logic [N-1:0]  outlier_count;
`ifdef WB_SCAN_EN
  logic          pt_valid;
  logic          pt_ready = 1'b0;
  logic [N-1:0]  pt_x, pt_y, pt_z;
`endif

  outlier_writeback #(.N(N), .BUS_SIZE(BW), .ADDR_W(AW), .MAX_WORDS(MW)) dut (
    .clock(clock), .reset(reset), .start(start), .empty(empty), .read_fifo(read_fifo),
    .outlier_pos_fifo(outlier_pos_fifo), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_rdata_x(bram_rdata_x), .bram_rdata_y(bram_rdata_y), .bram_rdata_z(bram_rdata_z),
    .bram_wdata_x(bram_wdata_x), .bram_wdata_y(bram_wdata_y), .bram_wdata_z(bram_wdata_z),
    .busy(busy), .wb_done(wb_done), .outlier_count(outlier_count)
`ifdef WB_SCAN_EN
    , .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // FIFO model: pushes from the stimulus process, pops from the clocked process.
  logic [N-1:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (rd_ptr == wr_ptr);
  always @(posedge clock) begin
    if (read_fifo && rd_ptr != wr_ptr) begin
      outlier_pos_fifo <= fifo_mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // BRAM model with a preload port so only this block writes the arrays.
  logic [BW-1:0] mem_x [0:MW-1];
  logic [BW-1:0] mem_y [0:MW-1];
  logic [BW-1:0] mem_z [0:MW-1];
  logic          ld_en = 1'b0;
  int            ld_addr = 0;
  logic [BW-1:0] ld_x = '0, ld_y = '0, ld_z = '0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  always @(posedge clock) begin
    if (ld_en) begin
      mem_x[ld_addr] <= ld_x;
      mem_y[ld_addr] <= ld_y;
      mem_z[ld_addr] <= ld_z;
    end
    if (bram_en) begin
      if (bram_we) begin
        mem_x[bram_addr] <= bram_wdata_x;
        mem_y[bram_addr] <= bram_wdata_y;
        mem_z[bram_addr] <= bram_wdata_z;
        wr_cnt <= wr_cnt + 1;
      end else begin
        bram_rdata_x <= mem_x[bram_addr];
        bram_rdata_y <= mem_y[bram_addr];
        bram_rdata_z <= mem_z[bram_addr];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // Protocol watcher: counted here, compared inside the scenario tasks.
  int viol = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (!bram_we && (bram_wdata_x != 0 || bram_wdata_y != 0 || bram_wdata_z != 0)) viol <= viol + 1;
      if (read_fifo && empty) viol <= viol + 1;
    end
  end

`ifdef WB_SCAN_EN
  logic [N-1:0] scan_q [$];
  always @(posedge clock) if (!reset && pt_valid && pt_ready) scan_q.push_back(pt_x);
  initial forever begin
    @(negedge clock);
    pt_ready = ~pt_ready;
  end
`endif

  // Reference model: expected word contents, count, write count and drain length.
  logic [BW-1:0] exp_x [0:MW-1];
  logic [BW-1:0] exp_y [0:MW-1];
  logic [BW-1:0] exp_z [0:MW-1];
  int exp_count = 0;
  int exp_cyc = 0;
  int exp_writes = 0;

  task automatic model_push(input int pos);
    int w;
    logic [BW-1:0] keep;
    fifo_mem[wr_ptr % 256] = N'(pos);
    wr_ptr = wr_ptr + 1;
    w = pos / 2;
    if (pos != 0 && w < MW) begin
      keep = (pos % 2 == 1) ? 32'h0000_FFFF : 32'hFFFF_0000;
      exp_x[w] = exp_x[w] & keep;
      exp_y[w] = exp_y[w] & keep;
      exp_z[w] = exp_z[w] & keep;
      exp_count = (exp_count == 65535) ? 65535 : exp_count + 1;
      exp_cyc += 6;
      exp_writes++;
    end else begin
      exp_cyc += 3;
    end
  endtask

  task automatic preload(input int a, input logic [BW-1:0] x, input logic [BW-1:0] y, input logic [BW-1:0] z);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = a; ld_x = x; ld_y = y; ld_z = z;
    exp_x[a] = x; exp_y[a] = y; exp_z[a] = z;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_count = 0;
    exp_cyc = 1;
    exp_writes = 0;
  endtask

  // Raises start, counts edges until wb_done, then releases start and returns to IDLE.
  task automatic run_drain(output int cyc);
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!wb_done && cyc < 5000);
    n_checks++;
    if (!wb_done) begin
      n_fail++;
      $display("FAIL drain_timeout: wb_done=%0b after %0d cycles, required 1", wb_done, cyc);
    end
    start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic check_word(input string name, input int a);
    n_checks++;
    if (mem_x[a] !== exp_x[a] || mem_y[a] !== exp_y[a] || mem_z[a] !== exp_z[a]) begin
      n_fail++;
      $display("FAIL %s word %0d: got %h/%h/%h, required %h/%h/%h", name, a,
               mem_x[a], mem_y[a], mem_z[a], exp_x[a], exp_y[a], exp_z[a]);
    end
  endtask

  task automatic check_totals(input string name, input int w0, input int cyc);
    n_checks++;
    if (outlier_count !== N'(exp_count)) begin
      n_fail++;
      $display("FAIL %s count: got %0d, required %0d", name, outlier_count, exp_count);
    end
    n_checks++;
    if (wr_cnt - w0 != exp_writes) begin
      n_fail++;
      $display("FAIL %s writes: got %0d, required %0d", name, wr_cnt - w0, exp_writes);
    end
`ifndef WB_SCAN_EN
    n_checks++;
    if (cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles to wb_done, required %0d", name, cyc, exp_cyc);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if (read_fifo !== 1'b0 || bram_en !== 1'b0 || busy !== 1'b0 || wb_done !== 1'b0 || outlier_count !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: rf=%b en=%b busy=%b done=%b cnt=%0d, required all 0",
                 i, read_fifo, bram_en, busy, wb_done, outlier_count);
      end
    end
  endtask

  task automatic test_single();
    int w0, cyc;
    do_reset();
    preload(2, 32'hAAAA_BBBB, 32'h1111_2222, 32'h3333_4444);
    w0 = wr_cnt;
    model_push(5);
    run_drain(cyc);
    n_checks++;
    if (mem_x[2] !== 32'h0000_BBBB) begin
      n_fail++;
      $display("FAIL single_x: got %h, required 0000bbbb", mem_x[2]);
    end
    check_word("single", 2);
    check_totals("single", w0, cyc);
  endtask

  task automatic test_same_word();
    int w0, cyc;
    do_reset();
    preload(3, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
    w0 = wr_cnt;
    model_push(6);
    model_push(7);
    run_drain(cyc);
    n_checks++;
    if (mem_x[3] !== 32'h0) begin
      n_fail++;
      $display("FAIL same_word_x: got %h, required 00000000", mem_x[3]);
    end
    check_word("same_word", 3);
    check_totals("same_word", w0, cyc);
  endtask

  task automatic test_drop();
    int w0, cyc;
    do_reset();
    preload(0, 32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h7777_8888);
    preload(2, 32'hDEAD_BEEF, 32'h5555_6666, 32'h9999_AAAA);
    w0 = wr_cnt;
    model_push(0);
    model_push(2 * MW + 1);
    model_push(4);
    run_drain(cyc);
    check_word("drop", 0);
    check_word("drop", 2);
    check_totals("drop", w0, cyc);
  endtask

  task automatic test_empty_start();
    int r0, w0, cyc;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      r0 = rd_cnt;
      w0 = wr_cnt;
      start = 1'b1;
      @(negedge clock);
      n_checks++;
      if (wb_done !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_start_done pass %0d: wb_done=%b busy=%b, required 1/0", k, wb_done, busy);
      end
      repeat (3) @(negedge clock);
      n_checks++;
      if (wb_done !== 1'b1) begin
        n_fail++;
        $display("FAIL empty_start_hold pass %0d: wb_done=%b, required 1", k, wb_done);
      end
      start = 1'b0;
      @(negedge clock);
      n_checks++;
      if (wb_done !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_start_release pass %0d: wb_done=%b, required 0", k, wb_done);
      end
      n_checks++;
      if (rd_cnt != r0 || wr_cnt != w0) begin
        n_fail++;
        $display("FAIL empty_start_bram pass %0d: %0d reads %0d writes, required 0/0", k, rd_cnt - r0, wr_cnt - w0);
      end
    end
    cyc = 0;
    exp_cyc = 1;
    run_drain(cyc);
    check_totals("empty_start", wr_cnt, cyc);
  endtask

  task automatic test_reset_rwait();
    int w0, cyc, guard;
    do_reset();
    preload(9, 32'h1357_2468, 32'hFEDC_BA98, 32'h0F0F_F0F0);
    w0 = wr_cnt;
    fifo_mem[wr_ptr % 256] = N'(18);
    wr_ptr = wr_ptr + 1;
    start = 1'b1;
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (!(bram_en && !bram_we) && guard < 50);
    n_checks++;
    if (!(bram_en && !bram_we)) begin
      n_fail++;
      $display("FAIL abort_read_seen: en=%b we=%b, required 1/0", bram_en, bram_we);
    end
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      n_checks++;
      if (bram_we !== 1'b0 || busy !== 1'b0 || wb_done !== 1'b0 || outlier_count !== '0) begin
        n_fail++;
        $display("FAIL abort_outputs: we=%b busy=%b done=%b cnt=%0d, required all 0", bram_we, busy, wb_done, outlier_count);
      end
    end
    reset = 1'b0;
    exp_count = 0;
    exp_writes = 0;
    exp_cyc = 1;
    repeat (3) @(negedge clock);
    check_word("abort", 9);
    run_drain(cyc);
    check_totals("abort", w0, cyc);
  endtask

  task automatic test_random();
    int w0, cyc, n, pos;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int a = 0; a < 32; a++)
        preload(a, BW'($urandom), BW'($urandom), BW'($urandom));
      w0 = wr_cnt;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        pos = ($urandom_range(0, 7) == 0) ? 2 * MW + $urandom_range(0, 9) : $urandom_range(0, 63);
        model_push(pos);
      end
      run_drain(cyc);
      for (int a = 0; a < 32; a++) check_word("random", a);
      check_totals("random", w0, cyc);
    end
  endtask

`ifdef WB_SCAN_EN
  task automatic test_scan();
    int base, cyc;
    do_reset();
    for (int a = 0; a < MW; a++) preload(a, 32'h0, 32'h0, 32'h0);
    preload(0, 32'h0001_0000, 32'h0009_0000, 32'h000A_0000);
    preload(1, 32'h0000_0002, 32'h0000_000B, 32'h0000_000C);
    base = scan_q.size();
    model_push(0);
    run_drain(cyc);
    n_checks++;
    if (scan_q.size() - base != 2) begin
      n_fail++;
      $display("FAIL scan_len: got %0d points, required 2", scan_q.size() - base);
    end else begin
      n_checks++;
      if (scan_q[base] !== 16'h0001 || scan_q[base + 1] !== 16'h0002) begin
        n_fail++;
        $display("FAIL scan_stream: got %h %h, required 0001 0002", scan_q[base], scan_q[base + 1]);
      end
    end
  endtask
`endif

  task automatic test_protocol();
    n_checks++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL protocol: %0d wdata-without-we or pop-while-empty cycles, required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_word();
    test_drop();
    test_empty_start();
    test_reset_rwait();
    test_random();
`ifdef WB_SCAN_EN
    test_scan();
`endif
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
